// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address, registers IF/ID.
// Optional memcopy wait state is enabled by defining MCOPY_STALL_EN.
module instr_fetch_unit #(
  parameter int unsigned             INS_ADDRESS = 32,
  parameter int unsigned             INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0]  RESET_PC    = '0,
  parameter logic [INS_ADDRESS-1:0]  PC_STEP     = 'h4,
  parameter logic [INS_W-1:0]        NOP_INSTR   = 'h13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_target,
`ifdef MCOPY_STALL_EN
  input  logic                   mcopy_done,
`endif
  output logic [INS_ADDRESS-1:0] imem_addr,
  input  logic [INS_W-1:0]       imem_instr,
  output logic [INS_W-1:0]       if_instr,
  output logic [INS_ADDRESS-1:0] if_pc,
  output logic [INS_ADDRESS-1:0] if_pc_next,
  output logic                   if_valid,
  output logic                   halted
);

`ifdef MCOPY_STALL_EN
  typedef enum logic [1:0] {StBoot, StRun, StHalt, StMcopyWait} state_e;
`else
  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;
`endif

  state_e                 state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d;
  logic [INS_W-1:0]       if_instr_q, if_instr_d;
  logic [INS_ADDRESS-1:0] if_pc_q, if_pc_d;
  logic [INS_ADDRESS-1:0] if_pc_next_q, if_pc_next_d;
  logic                   if_valid_q, if_valid_d;
  logic                   halted_q, halted_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pc_next_d = if_pc_next_q;
    if_valid_d   = if_valid_q;
    halted_d     = halted_q;

    case (state_q)
      StBoot: begin
        if_valid_d = 1'b0;
        state_d    = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          // Redirect wins over stall; the word in flight is wrong-path.
          pc_d       = redirect_target;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
        end else if (stall) begin
          // Everything holds.
        end else if (imem_instr == '0) begin
          if_valid_d = 1'b0;
          halted_d   = 1'b1;
          state_d    = StHalt;
        end else begin
          if_instr_d   = imem_instr;
          if_pc_d      = pc_q;
          if_pc_next_d = pc_q + PC_STEP;
          if_valid_d   = 1'b1;
          pc_d         = pc_q + PC_STEP;
`ifdef MCOPY_STALL_EN
          if (imem_instr[6:0] == 7'b1111111) state_d = StMcopyWait;
`endif
        end
      end
      StHalt: begin
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_instr_d = NOP_INSTR;
          halted_d   = 1'b0;
          state_d    = StRun;
        end
      end
`ifdef MCOPY_STALL_EN
      StMcopyWait: begin
        // Memcopy already issued once; hold fetch until the copy engine finishes.
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_instr_d = NOP_INSTR;
          state_d    = StRun;
        end else if (mcopy_done) begin
          state_d = StRun;
        end
      end
`endif
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= RESET_PC;
      if_pc_next_q <= RESET_PC + PC_STEP;
      if_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pc_next_q <= if_pc_next_d;
      if_valid_q   <= if_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_addr  = pc_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_pc_next = if_pc_next_q;
  assign if_valid   = if_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, reset and
// memcopy sequences, then randomized traffic against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        mcopy_done;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic        if_valid;
  logic        halted;

  logic        force_zero;
  logic        ovr_en;
  logic [31:0] ovr_word;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
`ifdef MCOPY_STALL_EN
    .mcopy_done      (mcopy_done),
`endif
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_next      (if_pc_next),
    .if_valid        (if_valid),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: never zero, never a memcopy opcode unless overridden.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, 16'h0513};
  endfunction

  assign imem_instr = ovr_en ? ovr_word : (force_zero ? 32'h0 : mem_word(imem_addr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_instr,
                         input logic [31:0] e_pc, input logic [31:0] e_pcn, input logic e_valid,
                         input logic e_halted);
    chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk({tag, ".if_instr"}, if_instr, e_instr);
    chk({tag, ".if_pc"}, if_pc, e_pc);
    chk({tag, ".if_pc_next"}, if_pc_next, e_pcn);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e_valid});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        zero;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pcn;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic s, input logic rv, input logic [31:0] tgt, input logic z,
                     input logic [31:0] a, input logic [31:0] p, input logic [31:0] pn,
                     input logic [31:0] ins, input logic v, input logic h);
    vec_t x;
    x.stall = s; x.rv = rv; x.tgt = tgt; x.zero = z;
    x.e_addr = a; x.e_pc = p; x.e_pcn = pn; x.e_instr = ins; x.e_valid = v; x.e_halted = h;
    vt.push_back(x);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    force_zero = 1'b0; ovr_en = 1'b0; ovr_word = '0; mcopy_done = 1'b0;
  endtask

  // Behavioural model: architectural fetch state advanced by the fetch rules.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipcn;
  logic        m_valid, m_halted, m_boot;

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_ipc = 32'd0; m_ipcn = 32'd4;
    m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [31:0] tgt, input logic z);
    logic [31:0] w;
    w = z ? 32'h0 : mem_word(m_pc);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      if (rv) begin
        m_pc = tgt; m_instr = NOP; m_halted = 1'b0;
      end
    end else if (rv) begin
      m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
    end else if (s) begin
      // hold
    end else if (w == 32'h0) begin
      m_valid = 1'b0; m_halted = 1'b1;
    end else begin
      m_instr = w; m_ipc = m_pc; m_ipcn = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Directed table (one row per rising edge after reset release).
    add(0, 0, 0, 0,   0,  0,  4, NOP,          0, 0);  // BOOT
    add(0, 0, 0, 0,   4,  0,  4, mem_word(0),  1, 0);
    add(0, 0, 0, 0,   8,  4,  8, mem_word(4),  1, 0);
    add(1, 0, 0, 0,   8,  4,  8, mem_word(4),  1, 0);  // stall x3 at pc=8
    add(1, 0, 0, 0,   8,  4,  8, mem_word(4),  1, 0);
    add(1, 0, 0, 0,   8,  4,  8, mem_word(4),  1, 0);
    add(0, 0, 0, 0,  12,  8, 12, mem_word(8),  1, 0);
    add(0, 0, 0, 0,  16, 12, 16, mem_word(12), 1, 0);
    add(1, 1, 30, 0, 30, 12, 16, NOP,          0, 0);  // redirect beats stall
    add(0, 0, 0, 0,  34, 30, 34, mem_word(30), 1, 0);
    add(0, 1, 90, 0, 90, 30, 34, NOP,          0, 0);
    add(0, 0, 0, 1,  90, 30, 34, NOP,          0, 1);  // zero word -> halt
    add(0, 0, 0, 0,  90, 30, 34, NOP,          0, 1);
    add(0, 1, 58, 0, 58, 30, 34, NOP,          0, 0);  // redirect leaves halt
    add(0, 0, 0, 0,  62, 58, 62, mem_word(58), 1, 0);
    add(0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 58, 62, NOP, 0, 0);
    add(0, 0, 0, 0,  0, 32'hFFFFFFFC, 0, mem_word(32'hFFFFFFFC), 1, 0);  // wrap
    add(0, 1, 28, 0, 28, 32'hFFFFFFFC, 0, NOP,     0, 0);
    add(0, 0, 0, 0,  32, 28, 32, mem_word(28), 1, 0);
    add(0, 0, 0, 0,  36, 32, 36, mem_word(32), 1, 0);
    add(0, 0, 0, 0,  40, 36, 40, mem_word(36), 1, 0);

    #12;
    chk_all("reset", 0, NOP, 0, 4, 0, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      stall = vt[i].stall; redirect_valid = vt[i].rv;
      redirect_target = vt[i].tgt; force_zero = vt[i].zero;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_instr, vt[i].e_pc, vt[i].e_pcn,
              vt[i].e_valid, vt[i].e_halted);
      idle_inputs();
    end

    // Asynchronous reset mid-run at pc=40.
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 0, NOP, 0, 4, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("midreset_boot", 0, NOP, 0, 4, 0, 0);
    @(posedge clk); #1;
    chk_all("midreset_fetch0", 4, mem_word(0), 0, 4, 1, 0);

`ifdef MCOPY_STALL_EN
    redirect_valid = 1'b1; redirect_target = 32'd82;
    @(posedge clk); #1;
    idle_inputs();
    chk("mc.addr82", imem_addr, 32'd82);
    ovr_en = 1'b1; ovr_word = 32'h00B0007F;
    @(posedge clk); #1;
    ovr_en = 1'b0;
    chk_all("mc.issue", 86, 32'h00B0007F, 82, 86, 1, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("mc.wait_valid", {31'd0, if_valid}, 32'd0);
      chk("mc.wait_addr", imem_addr, 32'd86);
    end
    mcopy_done = 1'b1;
    @(posedge clk); #1;
    mcopy_done = 1'b0;
    chk("mc.done_valid", {31'd0, if_valid}, 32'd0);
    @(posedge clk); #1;
    chk_all("mc.resume", 90, mem_word(86), 86, 90, 1, 0);
`endif

    // Randomized traffic against the model.
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("rnd_reset", m_pc, m_instr, m_ipc, m_ipcn, m_valid, m_halted);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      stall          = ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_target = ($urandom_range(3) == 0) ? 32'hFFFFFFF8 + {28'd0, 4'($urandom_range(7))}
                                                 : $urandom;
      force_zero     = ($urandom_range(19) == 0);
      @(posedge clk);
      model_step(stall, redirect_valid, redirect_target, force_zero);
      #1;
      chk_all($sformatf("rnd%0d", n), m_pc, m_instr, m_ipc, m_ipcn, m_valid, m_halted);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
